// File: rtl/inst_mem_arbiter_pkg.sv
// Shared constants and helpers for the instruction-memory arbiter.
// Holds the bus widths, memory enable encodings, arbitration mode and port
// encodings, and the address legality check used by the arbiter top.
package inst_mem_arbiter_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;

  localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Default implemented depth of the instruction memory, in words.
  localparam int unsigned INST_MEM_NUM = 131071;

  localparam logic ARB_FIXED       = 1'b0;
  localparam logic ARB_ROUND_ROBIN = 1'b1;
  localparam logic ARB_PORT0       = 1'b0;
  localparam logic ARB_PORT1       = 1'b1;

  // A byte address is legal when it is word aligned and falls inside the
  // implemented words. The compare is done at 34 bits so that words*4 cannot
  // wrap for large memories.
  function automatic logic addr_legal(input logic [INST_ADDR_W-1:0] addr,
                                      input int unsigned words);
    logic [33:0] lim;
    lim = {2'b00, words} << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < lim);
  endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// One requester port of the instruction-memory arbiter.
//   req/addr      requester -> arbiter
//   gnt           arbiter -> requester, combinational acceptance
//   rvalid/rdata/err  arbiter -> requester, registered response
//
// Handshake: the requester raises req with a stable addr and holds both until
// it sees gnt=1 in a cycle; that cycle is the transfer. Exactly one cycle
// later rvalid pulses for one cycle with rdata (or err=1 and rdata=0 for an
// illegal address). There is no back-pressure on responses, and a new request
// may be presented in the same cycle the previous rvalid is high.
interface inst_mem_arbiter_if;
  import inst_mem_arbiter_pkg::*;

  logic                   req;
  logic [INST_ADDR_W-1:0] addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INST_DATA_W-1:0] rdata;
  logic                   err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/inst_mem_arbiter_arb_pick2.sv
// arb_pick2: pure combinational two-way winner select.
//   req[1:0]  requests, bit 0 = port 0, bit 1 = port 1
//   mode      ARB_FIXED or ARB_ROUND_ROBIN
//   force1    fixed mode: port 1 has starved and must win contention
//   rr_last   round-robin: port that won the most recent grant
//   gnt[1:0]  one-hot (or zero) grant
module arb_pick2
  import inst_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       mode,
  input  logic       force1,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (mode == ARB_FIXED) begin
          gnt = force1 ? 2'b10 : 2'b01;
        end else begin
          // Contention goes to the port that did not win last time.
          gnt = (rr_last == ARB_PORT0) ? 2'b10 : 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter: shares the single-port, combinational-read instruction
// memory between the IF-stage fetch (port 0) and a debug/loader reader
// (port 1). Grants are combinational; read data returns registered one cycle
// after the grant.
//   clk, rst   clock and asynchronous active-high reset
//   m0, m1     requester ports (slave side of inst_mem_arbiter_if)
//   mem_ce     memory chip enable, set only for a granted legal access
//   mem_addr   granted port's address, zero when nothing is granted
//   mem_inst   memory read data, combinational from mem_ce/mem_addr
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter bit          ARB_MODE     = ARB_FIXED,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_WORDS    = INST_MEM_NUM
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_mem_arbiter_if.slave      m0,
  inst_mem_arbiter_if.slave      m1,
  output logic                   mem_ce,
  output logic [INST_ADDR_W-1:0] mem_addr,
  input  logic [INST_DATA_W-1:0] mem_inst
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]             starve_cnt;
  logic                   rr_last;
  logic [1:0]             req;
  logic [1:0]             gnt;
  logic                   force1;
  logic                   any_gnt;
  logic                   legal;
  logic [INST_ADDR_W-1:0] sel_addr;

  // While reset is high nothing may be granted, so requests are masked here.
  assign req    = rst ? 2'b00 : {m1.req, m0.req};
  assign force1 = m1.req && (starve_cnt == LIMIT);

  arb_pick2 u_pick (
    .req     (req),
    .mode    (ARB_MODE),
    .force1  (force1),
    .rr_last (rr_last),
    .gnt     (gnt)
  );

  assign m0.gnt   = gnt[0];
  assign m1.gnt   = gnt[1];
  assign any_gnt  = |gnt;
  assign sel_addr = gnt[1] ? m1.addr : m0.addr;
  assign legal    = addr_legal(sel_addr, MEM_WORDS);

  // An illegal grant still consumes the cycle but never enables the memory.
  assign mem_ce   = (any_gnt && legal) ? CHIP_ENABLE : CHIP_DISABLE;
  assign mem_addr = any_gnt ? sel_addr : ZERO_WORD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0.rvalid  <= 1'b0;
      m0.err     <= 1'b0;
      m0.rdata   <= ZERO_WORD;
      m1.rvalid  <= 1'b0;
      m1.err     <= 1'b0;
      m1.rdata   <= ZERO_WORD;
      starve_cnt <= '0;
      rr_last    <= ARB_PORT1;
    end else begin
      m0.rvalid <= gnt[0];
      m0.err    <= gnt[0] & ~legal;
      if (gnt[0]) begin
        m0.rdata <= legal ? mem_inst : ZERO_WORD;
      end
      m1.rvalid <= gnt[1];
      m1.err    <= gnt[1] & ~legal;
      if (gnt[1]) begin
        m1.rdata <= legal ? mem_inst : ZERO_WORD;
      end
      // Counts consecutive lost cycles of a waiting port 1, saturating.
      if (!m1.req || gnt[1]) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (any_gnt) begin
        rr_last <= gnt[1];
      end
    end
  end

endmodule
